// File: rtl/ex_hazard_controller.sv
// ex_hazard_controller: EX-stage forwarding selects, load-use stall
// detection, run/step/halt control of the pipeline enable, and a
// counter of enabled cycles.

module ex_hazard_controller #(
   parameter int NB     = 32,
   parameter int NB_REG = 5
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_step_mode,
   input  logic              i_step,
   input  logic              i_halt,
   input  logic [NB_REG-1:0] i_id_rs,
   input  logic [NB_REG-1:0] i_id_rt,
   input  logic [NB_REG-1:0] i_id_ex_rs,
   input  logic [NB_REG-1:0] i_id_ex_rt,
   input  logic              i_id_ex_mem_read,
   input  logic              i_id_ex_alu_src,
   input  logic              i_id_ex_shamt_sel,
   input  logic [NB_REG-1:0] i_ex_mem_rd,
   input  logic [NB_REG-1:0] i_mem_wb_rd,
   input  logic              i_ex_mem_reg_write,
   input  logic              i_mem_wb_reg_write,
   output logic [1:0]        o_fwd_a,
   output logic [1:0]        o_fwd_b,
   output logic [1:0]        o_fwd_store,
   output logic              o_pipeline_enable,
   output logic              o_pc_write,
   output logic              o_if_id_write,
   output logic              o_id_ex_flush,
   output logic              o_halted,
   output logic [NB-1:0]     o_cycle_count
);

   typedef enum logic [1:0] {
      ST_RUN       = 2'd0,
      ST_STEP_WAIT = 2'd1,
      ST_STEP_EXEC = 2'd2,
      ST_HALTED    = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic            step_q, step_d;
   logic [NB-1:0]   cycle_count_q, cycle_count_d;

   logic            en;
   logic            halted;
   logic            step_edge;
   logic            hazard;
   logic            mem_hit_rs, mem_hit_rt;
   logic            wb_hit_rs, wb_hit_rt;

   // Stage hit detection; register 0 is hardwired and never forwards.
   always_comb begin
      mem_hit_rs = i_ex_mem_reg_write && (i_ex_mem_rd != '0) && (i_ex_mem_rd == i_id_ex_rs);
      mem_hit_rt = i_ex_mem_reg_write && (i_ex_mem_rd != '0) && (i_ex_mem_rd == i_id_ex_rt);
      wb_hit_rs  = i_mem_wb_reg_write && (i_mem_wb_rd != '0) && (i_mem_wb_rd == i_id_ex_rs);
      wb_hit_rt  = i_mem_wb_reg_write && (i_mem_wb_rd != '0) && (i_mem_wb_rd == i_id_ex_rt);
   end

   // Forwarding selects: MEM beats WB; shamt and immediate operands keep their own source.
   always_comb begin
      o_fwd_a     = 2'b00;
      o_fwd_b     = 2'b00;
      o_fwd_store = 2'b10;
      if (!i_id_ex_shamt_sel) begin
         if (mem_hit_rs) begin
            o_fwd_a = 2'b01;
         end else if (wb_hit_rs) begin
            o_fwd_a = 2'b10;
         end
      end
      if (!i_id_ex_alu_src) begin
         if (mem_hit_rt) begin
            o_fwd_b = 2'b01;
         end else if (wb_hit_rt) begin
            o_fwd_b = 2'b10;
         end
      end
      if (mem_hit_rt) begin
         o_fwd_store = 2'b00;
      end else if (wb_hit_rt) begin
         o_fwd_store = 2'b01;
      end
   end

   // Load-use hazard: the load in EX targets a source of the instruction in ID.
   always_comb begin
      hazard = i_id_ex_mem_read && (i_id_ex_rt != '0) &&
               ((i_id_ex_rt == i_id_rs) || (i_id_ex_rt == i_id_rt));
   end

   // Run/step/halt next state; a step edge wins over leaving step mode.
   always_comb begin
      state_d   = state_q;
      en        = 1'b0;
      halted    = 1'b0;
      step_edge = i_step && !step_q;
      case (state_q)
         ST_RUN: begin
            en = 1'b1;
            if (i_halt) begin
               state_d = ST_HALTED;
            end else if (i_step_mode) begin
               state_d = ST_STEP_WAIT;
            end
         end
         ST_STEP_WAIT: begin
            if (step_edge) begin
               state_d = ST_STEP_EXEC;
            end else if (!i_step_mode) begin
               state_d = ST_RUN;
            end
         end
         ST_STEP_EXEC: begin
            en = 1'b1;
            if (i_halt) begin
               state_d = ST_HALTED;
            end else begin
               state_d = ST_STEP_WAIT;
            end
         end
         ST_HALTED: begin
            halted = 1'b1;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   // Next values for the step edge register and the enabled-cycle counter.
   always_comb begin
      step_d        = i_step;
      cycle_count_d = cycle_count_q;
      if (en) begin
         cycle_count_d = cycle_count_q + NB'(1);
      end
   end

   // State, step history and counter registers with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q       <= ST_RUN;
         step_q        <= 1'b0;
         cycle_count_q <= '0;
      end else begin
         state_q       <= state_d;
         step_q        <= step_d;
         cycle_count_q <= cycle_count_d;
      end
   end

   assign o_pipeline_enable = en;
   assign o_pc_write        = en && !hazard;
   assign o_if_id_write     = en && !hazard;
   assign o_id_ex_flush     = en && hazard;
   assign o_halted          = halted;
   assign o_cycle_count     = cycle_count_q;

endmodule

// File: tb/tb_ex_hazard_controller.sv
// tb_ex_hazard_controller: directed vectors with a queue-based scoreboard.
// The stimulus side pushes the expected response for each cycle; the
// monitor pops and compares on the falling edge.

module tb_ex_hazard_controller;

   logic        i_clk;
   logic        i_reset;
   logic        i_step_mode;
   logic        i_step;
   logic        i_halt;
   logic [4:0]  i_id_rs, i_id_rt, i_id_ex_rs, i_id_ex_rt;
   logic        i_id_ex_mem_read, i_id_ex_alu_src, i_id_ex_shamt_sel;
   logic [4:0]  i_ex_mem_rd, i_mem_wb_rd;
   logic        i_ex_mem_reg_write, i_mem_wb_reg_write;
   logic [1:0]  o_fwd_a, o_fwd_b, o_fwd_store;
   logic        o_pipeline_enable, o_pc_write, o_if_id_write, o_id_ex_flush, o_halted;
   logic [31:0] o_cycle_count;

   logic        w_reset;
   logic [1:0]  w_fwd_a, w_fwd_b, w_fwd_store;
   logic        w_pipeline_enable, w_pc_write, w_if_id_write, w_id_ex_flush, w_halted;
   logic [3:0]  w_cycle_count;

   typedef struct {
      string       name;
      logic [1:0]  fa, fb, fs;
      logic        en, pcw, flush, halted;
      logic        chk_cnt;
      logic [31:0] cnt;
      logic        chk_w;
      logic [3:0]  wcnt;
   } exp_t;

   exp_t exp_q[$];
   exp_t cur;
   int   checks = 0;
   int   errors = 0;

   ex_hazard_controller #(.NB(32), .NB_REG(5)) dut (
      .i_clk              (i_clk),
      .i_reset            (i_reset),
      .i_step_mode        (i_step_mode),
      .i_step             (i_step),
      .i_halt             (i_halt),
      .i_id_rs            (i_id_rs),
      .i_id_rt            (i_id_rt),
      .i_id_ex_rs         (i_id_ex_rs),
      .i_id_ex_rt         (i_id_ex_rt),
      .i_id_ex_mem_read   (i_id_ex_mem_read),
      .i_id_ex_alu_src    (i_id_ex_alu_src),
      .i_id_ex_shamt_sel  (i_id_ex_shamt_sel),
      .i_ex_mem_rd        (i_ex_mem_rd),
      .i_mem_wb_rd        (i_mem_wb_rd),
      .i_ex_mem_reg_write (i_ex_mem_reg_write),
      .i_mem_wb_reg_write (i_mem_wb_reg_write),
      .o_fwd_a            (o_fwd_a),
      .o_fwd_b            (o_fwd_b),
      .o_fwd_store        (o_fwd_store),
      .o_pipeline_enable  (o_pipeline_enable),
      .o_pc_write         (o_pc_write),
      .o_if_id_write      (o_if_id_write),
      .o_id_ex_flush      (o_id_ex_flush),
      .o_halted           (o_halted),
      .o_cycle_count      (o_cycle_count)
   );

   // Narrow-counter copy so wrap-around is reached in a handful of cycles.
   ex_hazard_controller #(.NB(4), .NB_REG(5)) u_wrap (
      .i_clk              (i_clk),
      .i_reset            (w_reset),
      .i_step_mode        (1'b0),
      .i_step             (1'b0),
      .i_halt             (1'b0),
      .i_id_rs            (5'd0),
      .i_id_rt            (5'd0),
      .i_id_ex_rs         (5'd0),
      .i_id_ex_rt         (5'd0),
      .i_id_ex_mem_read   (1'b0),
      .i_id_ex_alu_src    (1'b0),
      .i_id_ex_shamt_sel  (1'b0),
      .i_ex_mem_rd        (5'd0),
      .i_mem_wb_rd        (5'd0),
      .i_ex_mem_reg_write (1'b0),
      .i_mem_wb_reg_write (1'b0),
      .o_fwd_a            (w_fwd_a),
      .o_fwd_b            (w_fwd_b),
      .o_fwd_store        (w_fwd_store),
      .o_pipeline_enable  (w_pipeline_enable),
      .o_pc_write         (w_pc_write),
      .o_if_id_write      (w_if_id_write),
      .o_id_ex_flush      (w_id_ex_flush),
      .o_halted           (w_halted),
      .o_cycle_count      (w_cycle_count)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic cmp(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", n, act, exp);
      end
   endtask

   task automatic checkOutput(input exp_t e);
      cmp({e.name, ".fwd_a"},     32'(o_fwd_a),           32'(e.fa));
      cmp({e.name, ".fwd_b"},     32'(o_fwd_b),           32'(e.fb));
      cmp({e.name, ".fwd_store"}, 32'(o_fwd_store),       32'(e.fs));
      cmp({e.name, ".enable"},    32'(o_pipeline_enable), 32'(e.en));
      cmp({e.name, ".pc_write"},  32'(o_pc_write),        32'(e.pcw));
      cmp({e.name, ".if_id_wr"},  32'(o_if_id_write),     32'(e.pcw));
      cmp({e.name, ".flush"},     32'(o_id_ex_flush),     32'(e.flush));
      cmp({e.name, ".halted"},    32'(o_halted),          32'(e.halted));
      if (e.chk_cnt) cmp({e.name, ".count"}, o_cycle_count, e.cnt);
      if (e.chk_w)   cmp({e.name, ".wrap_count"}, 32'(w_cycle_count), 32'(e.wcnt));
   endtask

   // Monitor: one expected entry per cycle, compared mid-cycle.
   always @(negedge i_clk) begin
      if (exp_q.size() > 0) begin
         cur = exp_q.pop_front();
         checkOutput(cur);
      end
   end

   function automatic void pushExpect(input string n, input logic [1:0] fa, input logic [1:0] fb,
                                      input logic [1:0] fs, input logic en, input logic pcw,
                                      input logic flush, input logic halted, input logic cc,
                                      input logic [31:0] cnt);
      exp_t e;
      e.name = n; e.fa = fa; e.fb = fb; e.fs = fs;
      e.en = en; e.pcw = pcw; e.flush = flush; e.halted = halted;
      e.chk_cnt = cc; e.cnt = cnt; e.chk_w = 1'b0; e.wcnt = 4'd0;
      exp_q.push_back(e);
   endfunction

   function automatic void expIdle(input string n, input logic en, input logic halted,
                                   input logic cc, input logic [31:0] cnt);
      pushExpect(n, 2'b00, 2'b00, 2'b10, en, en, 1'b0, halted, cc, cnt);
   endfunction

   function automatic void pushWrap(input string n, input logic [3:0] wcnt);
      exp_t e;
      e.name = n; e.fa = 2'b00; e.fb = 2'b00; e.fs = 2'b10;
      e.en = 1'b1; e.pcw = 1'b1; e.flush = 1'b0; e.halted = 1'b0;
      e.chk_cnt = 1'b0; e.cnt = 32'd0; e.chk_w = 1'b1; e.wcnt = wcnt;
      exp_q.push_back(e);
   endfunction

   // Start a new cycle just after the rising edge with all inputs idle.
   task automatic applyStimulus();
      @(posedge i_clk);
      #1;
      i_reset = 1'b0; w_reset = 1'b0;
      i_step_mode = 1'b0; i_step = 1'b0; i_halt = 1'b0;
      i_id_rs = 5'd0; i_id_rt = 5'd0; i_id_ex_rs = 5'd0; i_id_ex_rt = 5'd0;
      i_id_ex_mem_read = 1'b0; i_id_ex_alu_src = 1'b0; i_id_ex_shamt_sel = 1'b0;
      i_ex_mem_rd = 5'd0; i_mem_wb_rd = 5'd0;
      i_ex_mem_reg_write = 1'b0; i_mem_wb_reg_write = 1'b0;
   endtask

   initial begin
      int guard;
      i_reset = 1'b1; w_reset = 1'b1;
      i_step_mode = 1'b0; i_step = 1'b0; i_halt = 1'b0;
      i_id_rs = 5'd0; i_id_rt = 5'd0; i_id_ex_rs = 5'd0; i_id_ex_rt = 5'd0;
      i_id_ex_mem_read = 1'b0; i_id_ex_alu_src = 1'b0; i_id_ex_shamt_sel = 1'b0;
      i_ex_mem_rd = 5'd0; i_mem_wb_rd = 5'd0;
      i_ex_mem_reg_write = 1'b0; i_mem_wb_reg_write = 1'b0;
      repeat (3) @(posedge i_clk);

      // Reset state
      applyStimulus(); expIdle("reset", 1, 0, 1, 32'd0);

      // Forwarding priority on operand A
      applyStimulus(); i_id_ex_rs = 5; i_ex_mem_rd = 5; i_ex_mem_reg_write = 1; i_mem_wb_rd = 5; i_mem_wb_reg_write = 1;
      pushExpect("fa_mem", 2'b01, 2'b00, 2'b10, 1, 1, 0, 0, 0, 0);
      applyStimulus(); i_id_ex_rs = 5; i_ex_mem_rd = 5; i_mem_wb_rd = 5; i_mem_wb_reg_write = 1;
      pushExpect("fa_wb", 2'b10, 2'b00, 2'b10, 1, 1, 0, 0, 0, 0);
      applyStimulus(); i_id_ex_rs = 5; i_ex_mem_reg_write = 1; i_mem_wb_reg_write = 1;
      pushExpect("fa_r0", 2'b00, 2'b00, 2'b10, 1, 1, 0, 0, 0, 0);

      // Immediate / shamt suppression and store-data select
      applyStimulus(); i_id_ex_rt = 7; i_ex_mem_rd = 7; i_ex_mem_reg_write = 1; i_id_ex_alu_src = 1;
      pushExpect("fb_imm", 2'b00, 2'b00, 2'b00, 1, 1, 0, 0, 0, 0);
      applyStimulus(); i_id_ex_rt = 7; i_ex_mem_rd = 7; i_ex_mem_reg_write = 1;
      pushExpect("fb_mem", 2'b00, 2'b01, 2'b00, 1, 1, 0, 0, 0, 0);
      applyStimulus(); i_id_ex_rt = 7; i_ex_mem_rd = 7; i_mem_wb_rd = 7; i_mem_wb_reg_write = 1;
      pushExpect("fb_wb", 2'b00, 2'b10, 2'b01, 1, 1, 0, 0, 0, 0);
      applyStimulus(); i_id_ex_rs = 9; i_ex_mem_rd = 9; i_ex_mem_reg_write = 1; i_id_ex_shamt_sel = 1;
      pushExpect("fa_shamt", 2'b00, 2'b00, 2'b10, 1, 1, 0, 0, 0, 0);
      applyStimulus(); i_id_ex_rs = 9; i_ex_mem_rd = 9; i_ex_mem_reg_write = 1;
      pushExpect("fa_noshamt", 2'b01, 2'b00, 2'b10, 1, 1, 0, 0, 0, 0);

      // Load-use stall
      applyStimulus(); i_id_ex_mem_read = 1; i_id_ex_rt = 3; i_id_rs = 3;
      pushExpect("lu_rs", 2'b00, 2'b00, 2'b10, 1, 0, 1, 0, 0, 0);
      applyStimulus(); expIdle("lu_clear", 1, 0, 0, 0);
      applyStimulus(); i_id_ex_mem_read = 1;
      expIdle("lu_r0", 1, 0, 0, 0);
      applyStimulus(); i_id_ex_mem_read = 1; i_id_ex_rt = 4; i_id_rt = 4; i_id_rs = 2;
      pushExpect("lu_rt", 2'b00, 2'b00, 2'b10, 1, 0, 1, 0, 0, 0);
      applyStimulus(); expIdle("run_count", 1, 0, 1, 32'd13);

      // Step mode with i_step held for four cycles
      applyStimulus(); i_step_mode = 1;
      expIdle("enter_step", 1, 0, 1, 32'd14);
      applyStimulus(); i_step_mode = 1;
      expIdle("step_wait", 0, 0, 1, 32'd15);
      applyStimulus(); i_step_mode = 1; i_step = 1; i_id_ex_mem_read = 1; i_id_ex_rt = 3; i_id_rs = 3;
      pushExpect("wait_nostall", 2'b00, 2'b00, 2'b10, 0, 0, 0, 0, 1, 32'd15);
      applyStimulus(); i_step_mode = 1; i_step = 1;
      expIdle("step_exec", 1, 0, 1, 32'd15);
      applyStimulus(); i_step_mode = 1; i_step = 1;
      expIdle("step_held1", 0, 0, 1, 32'd16);
      applyStimulus(); i_step_mode = 1; i_step = 1;
      expIdle("step_held2", 0, 0, 1, 32'd16);
      applyStimulus(); i_step_mode = 1;
      expIdle("step_low", 0, 0, 1, 32'd16);
      applyStimulus();
      expIdle("leave_step", 0, 0, 1, 32'd16);

      // Halt from RUN, step ignored while halted, reset recovers
      applyStimulus(); i_halt = 1;
      expIdle("halt_sample", 1, 0, 1, 32'd16);
      applyStimulus(); expIdle("halted", 0, 1, 1, 32'd17);
      applyStimulus(); i_step_mode = 1; i_step = 1;
      expIdle("halt_step", 0, 1, 1, 32'd17);
      applyStimulus(); i_halt = 1;
      expIdle("halt_hold", 0, 1, 1, 32'd17);
      applyStimulus(); i_reset = 1;
      expIdle("halt_rst", 0, 1, 1, 32'd17);
      applyStimulus(); expIdle("post_rst", 1, 0, 1, 32'd0);

      // Halt ignored in STEP_WAIT, honoured in STEP_EXEC
      applyStimulus(); i_step_mode = 1;
      expIdle("s2_enter", 1, 0, 1, 32'd1);
      applyStimulus(); i_step_mode = 1; i_halt = 1;
      expIdle("s2_wait_halt", 0, 0, 1, 32'd2);
      applyStimulus(); i_step_mode = 1; i_step = 1;
      expIdle("s2_wait_step", 0, 0, 1, 32'd2);
      applyStimulus(); i_step_mode = 1; i_step = 1; i_halt = 1;
      expIdle("s2_exec_halt", 1, 0, 1, 32'd2);
      applyStimulus(); expIdle("s2_halted", 0, 1, 1, 32'd3);
      applyStimulus(); i_reset = 1;
      expIdle("s2_rst", 0, 1, 1, 32'd3);
      applyStimulus(); expIdle("s2_run", 1, 0, 1, 32'd0);

      // Reset mid-step
      applyStimulus(); i_step_mode = 1;
      expIdle("s3_enter", 1, 0, 1, 32'd1);
      applyStimulus(); i_step_mode = 1; i_reset = 1;
      expIdle("s3_wait_rst", 0, 0, 1, 32'd2);
      applyStimulus(); expIdle("s3_run", 1, 0, 1, 32'd0);

      // Step edge beats leaving step mode
      applyStimulus(); i_step_mode = 1;
      expIdle("s4_enter", 1, 0, 1, 32'd1);
      applyStimulus(); i_step = 1;
      expIdle("s4_wait_both", 0, 0, 1, 32'd2);
      applyStimulus(); expIdle("s4_exec", 1, 0, 1, 32'd2);
      applyStimulus(); expIdle("s4_wait", 0, 0, 1, 32'd3);
      applyStimulus(); expIdle("s4_run", 1, 0, 1, 32'd3);

      // Counter wrap on the narrow instance
      applyStimulus(); w_reset = 1;
      expIdle("wrap_rst", 1, 0, 0, 0);
      for (int i = 0; i < 18; i++) begin
         applyStimulus();
         pushWrap($sformatf("wrap%0d", i), 4'(i));
      end

      guard = 0;
      while (exp_q.size() > 0 && guard < 20) begin
         @(negedge i_clk);
         #1;
         guard++;
      end
      if (exp_q.size() > 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
